poly_mac_acc: RTL



---
 rtl/poly_pkg.sv | 16 +
 rtl/mult_64.sv | 29 ++
 rtl/poly_mac_acc.sv | 118 +++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// Shared widths and defaults for the polynomial MAC datapath and its multiplier.
package poly_pkg;
    localparam int MULT_LATENCY_DEF = 6;
    localparam int ACC_W_DEF        = 136;
    localparam int MAX_TERMS_DEF    = 256;
    localparam int CNT_W            = 9;
    localparam int OPND_W           = 64;
    localparam int PROD_W           = 128;

    // Sideband tag that travels beside each product through the multiplier latency.
    typedef struct packed {
        logic vld;
        logic last;
        logic forced;
    } tag_t;
endpackage

// File: rtl/mult_64.sv
// Pipelined 64x64 unsigned multiplier: operands captured on one edge, product at P LATENCY edges later.
module mult_64
    import poly_pkg::*;
#(
    parameter int LATENCY = MULT_LATENCY_DEF
) (
    input  logic              CLK,
    input  logic [OPND_W-1:0] A,
    input  logic [OPND_W-1:0] B,
    output logic [PROD_W-1:0] P
);

    logic [OPND_W-1:0]              a_q;
    logic [OPND_W-1:0]              b_q;
    logic [LATENCY-1:0][PROD_W-1:0] p_pipe;

    // Data pipe carries no reset; downstream tags decide which products count.
    always_ff @(posedge CLK) begin
        a_q       <= A;
        b_q       <= B;
        p_pipe[0] <= PROD_W'(a_q) * PROD_W'(b_q);
        for (int i = 1; i < LATENCY; i++) begin
            p_pipe[i] <= p_pipe[i-1];
        end
    end

    assign P = p_pipe[LATENCY-1];

endmodule

// File: rtl/poly_mac_acc.sv
// Sum-of-products accumulator: groups of operand pairs are multiplied and summed into one result.
module poly_mac_acc
    import poly_pkg::*;
#(
    parameter int MULT_LATENCY = MULT_LATENCY_DEF,
    parameter int ACC_W        = ACC_W_DEF,
    parameter int MAX_TERMS    = MAX_TERMS_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_forced
);

    logic [PROD_W-1:0]       prod;
    logic                    ready_q;
    logic                    accept;
    logic                    at_limit;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CNT_W-1:0]        acc_cnt;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;
    logic                    last_in_flight;
    logic                    lif_nxt;
    logic                    ov_nxt;
    logic                    handshake;
    logic                    load;
    tag_t                    tag_in;
    tag_t                    tag_end;
    tag_t [MULT_LATENCY:0]   tag_pipe;

    mult_64 #(.LATENCY(MULT_LATENCY)) u_mult (
        .CLK (CLK),
        .A   (in_a),
        .B   (in_b),
        .P   (prod)
    );

    assign in_ready  = ready_q;
    assign accept    = in_valid && ready_q;
    assign at_limit  = (beat_cnt == CNT_W'(MAX_TERMS - 1));
    assign handshake = out_valid && out_ready;

    // A group closes on in_last or when the term limit is reached; only the latter is "forced".
    always_comb begin
        tag_in        = '0;
        tag_in.vld    = accept;
        tag_in.last   = accept && (in_last || at_limit);
        tag_in.forced = accept && at_limit && !in_last;
    end

    assign tag_end = tag_pipe[MULT_LATENCY];
    assign load    = tag_end.vld && tag_end.last;
    assign acc_sum = acc + ACC_W'(prod);

    always_comb begin
        lif_nxt = last_in_flight;
        if (load)
            lif_nxt = 1'b0;
        if (tag_in.last)
            lif_nxt = 1'b1;
        ov_nxt = out_valid;
        if (handshake)
            ov_nxt = 1'b0;
        if (load)
            ov_nxt = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_pipe       <= '0;
            ready_q        <= 1'b0;
            last_in_flight <= 1'b0;
            beat_cnt       <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i <= MULT_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            ready_q        <= !(lif_nxt || ov_nxt);
            last_in_flight <= lif_nxt;
            if (accept)
                beat_cnt <= tag_in.last ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc        <= '0;
            acc_cnt    <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_count  <= '0;
            out_forced <= 1'b0;
        end else begin
            out_valid <= ov_nxt;
            if (load) begin
                out_sum    <= acc_sum;
                out_count  <= acc_cnt + 1'b1;
                out_forced <= tag_end.forced;
                acc        <= '0;
                acc_cnt    <= '0;
            end else if (tag_end.vld) begin
                acc     <= acc_sum;
                acc_cnt <= acc_cnt + 1'b1;
            end
        end
    end

endmodule
